// File: rtl/vga_mode_sched_if.sv
// Signal bundle between the VGA frame source/controls and the picture-mode scheduler.
// The master drives sync and requests; the slave (scheduler) drives the mode outputs.
interface vga_mode_sched_if;
  logic       vsync;
  logic       next_req;
  logic       auto_tgl;
  logic [2:0] mode;
  logic       mode_upd;
  logic       auto_on;
  logic [7:0] frame_cnt;
  logic       blank;

  modport master (
    output vsync, next_req, auto_tgl,
    input  mode, mode_upd, auto_on, frame_cnt, blank
  );

  modport slave (
    input  vsync, next_req, auto_tgl,
    output mode, mode_upd, auto_on, frame_cnt, blank
  );
endinterface

// File: rtl/vga_mode_sched.sv
// Picture-mode scheduler: manual/auto mode stepping, applied only on frame boundaries.
// Optional macro VGA_MODE_BLANK_EN blanks one full frame after every mode change.
module vga_mode_sched #(
  parameter int MODE_NUM    = 4,
  parameter int AUTO_FRAMES = 60
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  vga_mode_sched_if.slave  bus
);

  localparam logic [2:0] MODE_LAST = 3'(MODE_NUM - 1);
  localparam logic [7:0] CNT_LAST  = 8'(AUTO_FRAMES - 1);

  typedef enum logic {ST_MAN = 1'b0, ST_AUTO = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic       vsync_d_reg;
  logic       armed_reg;
  logic       pending_reg, pending_next;
  logic       mode_upd_reg, mode_upd_next;
  logic [2:0] mode_reg, mode_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       frame_tick;
  logic       advance;

  // armed_reg suppresses a tick when vsync is already high as reset releases
  assign frame_tick = bus.vsync & ~vsync_d_reg & armed_reg;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_MAN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.auto_tgl) begin
      state_next = (state_reg == ST_MAN) ? ST_AUTO : ST_MAN;
    end
  end

  always_comb begin
    advance = 1'b0;
    if (frame_tick) begin
      advance = pending_reg;
      if (!bus.auto_tgl && (state_reg == ST_AUTO) && !pending_reg && (cnt_reg == CNT_LAST)) begin
        advance = 1'b1;
      end
    end

    // A toggle on a tick skips the auto-count, but a pending advance still lands
    cnt_next = cnt_reg;
    if (bus.auto_tgl || (state_reg == ST_MAN)) begin
      cnt_next = 8'd0;
    end else if (frame_tick) begin
      cnt_next = (pending_reg || (cnt_reg == CNT_LAST)) ? 8'd0 : cnt_reg + 8'd1;
    end

    // A request coinciding with a tick survives the clear and waits for the next one
    pending_next = (pending_reg & ~frame_tick) | bus.next_req;

    mode_next = mode_reg;
    if (advance) begin
      mode_next = (mode_reg == MODE_LAST) ? 3'd0 : mode_reg + 3'd1;
    end
    mode_upd_next = advance;
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vsync_d_reg  <= 1'b0;
      armed_reg    <= 1'b0;
      pending_reg  <= 1'b0;
      mode_reg     <= 3'd0;
      mode_upd_reg <= 1'b0;
      cnt_reg      <= 8'd0;
    end else begin
      vsync_d_reg  <= bus.vsync;
      armed_reg    <= armed_reg | ~bus.vsync;
      pending_reg  <= pending_next;
      mode_reg     <= mode_next;
      mode_upd_reg <= mode_upd_next;
      cnt_reg      <= cnt_next;
    end
  end

`ifdef VGA_MODE_BLANK_EN
  logic blank_reg;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blank_reg <= 1'b0;
    end else if (mode_upd_next) begin
      blank_reg <= 1'b1;
    end else if (frame_tick) begin
      blank_reg <= 1'b0;
    end
  end
`endif

  always_comb begin
    bus.mode      = mode_reg;
    bus.mode_upd  = mode_upd_reg;
    bus.auto_on   = (state_reg == ST_AUTO);
    bus.frame_cnt = cnt_reg;
`ifdef VGA_MODE_BLANK_EN
    bus.blank     = blank_reg;
`else
    bus.blank     = 1'b0;
`endif
  end

endmodule

// File: doc/vga_mode_sched.md
VGA_MODE_SCHED -- requirements
Module: vga_mode_sched

Interface
REQ-001 SHALL have parameter MODE_NUM, default 4, number of picture modes; legal range 2..8.
REQ-002 SHALL have parameter AUTO_FRAMES, default 60, frames per mode in auto state; legal range 1..255.
REQ-003 SHALL have port vga_clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vsync  input  1  active-high frame sync from vga_ctrl, synchronous to vga_clk.
REQ-006 SHALL have port next_req  input  1  single-cycle request to advance mode.
REQ-007 SHALL have port auto_tgl  input  1  single-cycle request to toggle auto/manual.
REQ-008 SHALL have port mode  output  3  current picture mode to vga_pic; range 0..MODE_NUM-1.
REQ-009 SHALL have port mode_upd  output  1  one-cycle pulse in the first cycle a new mode value is driven.
REQ-010 SHALL have port auto_on  output  1  high while in AUTO state.
REQ-011 SHALL have port frame_cnt  output  8  frames elapsed in current mode (AUTO only).
REQ-012 SHALL have port blank  output  1  request to vga_pic to output black.

Function
REQ-013 SHALL register vsync into vsync_d every cycle; frame_tick = vsync & ~vsync_d (internal, one cycle per frame).
REQ-014 SHALL implement two states, MAN and AUTO; auto_tgl toggles state in the cycle after it is sampled.
REQ-015 SHALL clear frame_cnt to 0 on every state change.
REQ-016 SHALL latch next_req into a pending flag; repeated next_req while pending SHALL NOT queue a second advance.
REQ-017 SHALL apply a pending advance only on frame_tick: mode becomes mode+1, or 0 when mode == MODE_NUM-1; pending clears.
REQ-018 SHALL, in the same tick, ignore a next_req arriving with frame_tick; it becomes pending and applies at the following tick.
REQ-019 SHALL, in AUTO on frame_tick without pending advance, increment frame_cnt; when frame_cnt == AUTO_FRAMES-1, advance mode and set frame_cnt to 0.
REQ-020 SHALL, in AUTO, reset frame_cnt to 0 when a pending advance is applied.
REQ-021 SHALL hold frame_cnt at 0 in MAN.
REQ-022 SHALL, when auto_tgl and frame_tick coincide, perform the toggle, skip the auto-count update for that tick, and still apply any pending advance.
REQ-023 SHALL update mode one cycle after frame_tick (registered) and assert mode_upd for exactly that cycle.
REQ-024 SHALL never change mode other than as a result of frame_tick.

Reset
REQ-025 SHALL, on sys_rst high, asynchronously force: state MAN, mode 0, mode_upd 0, auto_on 0, frame_cnt 0, blank 0, pending 0, vsync_d 0.
REQ-026 SHALL resume normal operation on the first vga_clk edge after sys_rst deasserts; a vsync high at release SHALL NOT generate frame_tick until vsync has been seen low.

Configuration
REQ-027 SHALL honour macro VGA_MODE_BLANK_EN: when defined, blank goes high with mode_upd and stays high until the next frame_tick, then falls in the cycle after it (one full frame blanked per mode change).
REQ-028 SHALL, without VGA_MODE_BLANK_EN, drive blank constant 0 and add no blank logic.

Verification
REQ-029 SHALL verify: reset released, 3 next_req pulses within one frame -> one mode_upd at the next tick, mode 0->1.
REQ-030 SHALL verify: MODE_NUM=4, mode=3, next_req then tick -> mode 0, mode_upd 1 cycle.
REQ-031 SHALL verify: AUTO_FRAMES=3, auto_tgl then 7 frames -> mode 0->1 at tick 3 and 1->2 at tick 6, frame_cnt 0,1,2,0,1,2,0.
REQ-032 SHALL verify: next_req in the same cycle as frame_tick -> no change that tick, mode_upd exactly 1 cycle after the next tick.
REQ-033 SHALL verify: sys_rst asserted mid-frame in AUTO with pending advance -> all outputs 0 immediately, no mode_upd after release.
REQ-034 SHALL verify: VGA_MODE_BLANK_EN defined, mode change -> blank high from mode_upd through the next frame_tick+1 cycle; undefined -> blank always 0.
